fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DATA_WIDTH    : width of PC, fetch address and instruction word
//   RESET_PC      : first fetch address after reset
//   fetch_state_t : fetch FSM state (FETCH / WAIT / DISCARD)
//   fetch_entry_t : one {pc, instr} buffer entry handed to decode
package fetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  // FETCH   : nothing outstanding, may issue a request
  // WAIT    : one request outstanding, its response will be kept
  // DISCARD : one request outstanding, its response is stale and dropped
  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries toward decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry (ignored during flush)
//   pop        : remove the head entry (caller guarantees non-empty)
//   flush      : empty the buffer; dominates push and pop
//   count      : number of valid entries
//   head       : oldest entry, all-zero while the buffer is empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array is deliberately not reset; only pointers and
  // count are, and the head is masked to zero while empty, so stale words
  // are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word-aligned fetch at a time to
// instruction memory, buffers responses with their PC, and hands them to
// decode through a valid/ready handshake. Redirects from execute flush the
// buffer and cause any in-flight response to be discarded.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req/imem_addr      : fetch request and its address
//   imem_rvalid/imem_rdata  : memory response (1+ cycles after request)
//   redirect/redirect_pc    : taken branch/jump target from execute
//   valid_d/ready_d         : decode handshake (pop on valid_d & ready_d)
//   instr_d/pc_d/pcplus4_d  : buffered instruction, its PC and PC+4
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = fetch_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  valid_d,
  input  logic                  ready_d,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pcplus4_d
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;       // next address to fetch
  logic [DATA_WIDTH-1:0] req_pc;   // address of the outstanding request
  logic [CW-1:0]         count;
  fetch_entry_t          head;
  logic                  push;
  logic                  pop;

  // Requests only with nothing outstanding and room for the response, so a
  // push can never hit a full buffer. Gating with rst_n keeps the request
  // low during reset and lets the first one be taken on the first edge
  // after release.
  assign imem_req  = rst_n && (state == FETCH) && (count < CW'(FIFO_DEPTH)) && !redirect;
  assign imem_addr = pc;

  // A response is kept only for a live request and only if no redirect
  // arrives in the same cycle.
  assign push = (state == WAIT) && imem_rvalid && !redirect;
  assign pop  = valid_d && ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redirect) pc <= redirect_pc & ~DATA_WIDTH'(3);
      else if (imem_req) pc <= pc + DATA_WIDTH'(4);

      if (imem_req) req_pc <= pc;

      case (state)
        FETCH:   if (imem_req) state <= WAIT;
        WAIT: begin
          if (imem_rvalid)   state <= FETCH;
          else if (redirect) state <= DISCARD;
        end
        DISCARD: if (imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ('{pc: req_pc, instr: imem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .count (count),
    .head  (head)
  );

  // Decode outputs come straight from buffer registers; pcplus4_d is
  // masked so every decode output reads zero while nothing is valid.
  assign valid_d   = (count != '0);
  assign instr_d   = head.instr;
  assign pc_d      = head.pc;
  assign pcplus4_d = valid_d ? head.pc + DATA_WIDTH'(4) : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction memory model
// (configurable response latency, word = {16'hDEAD, addr[15:0]}).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        valid_d;
  logic        ready_d = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;

  always #5 clk = ~clk;

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_d     (valid_d),
    .ready_d     (ready_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcplus4_d   (pcplus4_d)
  );

  int checks = 0;
  int failures = 0;

  // memory model state
  int          lat = 1;
  bit          mem_en = 1'b1;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  // observation logs
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic [31:0] pop_pp4[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hDEAD, a[15:0]};
  endfunction

  // One clock cycle: log what the DUT presents before the edge, advance,
  // then drive the memory response for the new cycle.
  task automatic step();
    bit          acc;
    logic [31:0] a;
    acc = (imem_req === 1'b1);
    a   = imem_addr;
    if (acc) acc_q.push_back(a);
    if (valid_d === 1'b1 && ready_d) begin
      pop_pc.push_back(pc_d);
      pop_instr.push_back(instr_d);
      pop_pp4.push_back(pcplus4_d);
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (acc && mem_en) begin
      pending = 1'b1;
      cnt     = lat;
      paddr   = a;
    end
    if (pending) begin
      if (cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(paddr);
        pending     = 1'b0;
      end else begin
        cnt--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ready_d     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pending     = 1'b0;
    mem_en      = 1'b1;
    lat         = 1;
    acc_q.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_pp4.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_d); end
    checks++; if (pc_d !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_d); end
    checks++; if (pcplus4_d !== 32'h0) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=0", pcplus4_d); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL release_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a [4];
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    ready_d = 1'b1;
    step();
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL seq_latency_early got=%b exp=0", valid_d); end
    step();
    checks++; if (valid_d !== 1'b1) begin failures++; $display("FAIL seq_latency_valid got=%b exp=1", valid_d); end
    checks++; if (pc_d !== 32'h0) begin failures++; $display("FAIL seq_first_pc got=%h exp=0", pc_d); end
    checks++; if (instr_d !== 32'hDEAD_0000) begin failures++; $display("FAIL seq_first_instr got=%h exp=dead0000", instr_d); end
    checks++; if (pcplus4_d !== 32'h4) begin failures++; $display("FAIL seq_first_pcplus4 got=%h exp=4", pcplus4_d); end
    repeat (6) step();
    checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL seq_req_count got=%0d exp=4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_a[i]) begin failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, acc_q[i], exp_a[i]); end
    end
    checks++; if (pop_pc.size() != 3) begin failures++; $display("FAIL seq_pop_count got=%0d exp=3", pop_pc.size()); end
    for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== exp_a[i]) begin failures++; $display("FAIL seq_pop_pc[%0d] got=%h exp=%h", i, pop_pc[i], exp_a[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_d = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c >= 4) begin
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_full_req cycle=%0d got=%b exp=0", c, imem_req); end
      end
    end
    checks++; if (acc_q.size() != 2) begin failures++; $display("FAIL bp_buffered got=%0d exp=2", acc_q.size()); end
    checks++; if (pc_d !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%h exp=0", pc_d); end
    ready_d = 1'b1;
    repeat (8) step();
    checks++; if (pop_pc.size() != 5) begin failures++; $display("FAIL bp_pop_count got=%0d exp=5", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      checks++;
      if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== word_of(32'(4 * i))) begin
        failures++;
        $display("FAIL bp_order[%0d] got=%h/%h exp=%h/%h", i, pop_pc[i], pop_instr[i], 32'(4 * i), word_of(32'(4 * i)));
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ready_d = 1'b1;
    lat = 3;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_req_in_redirect got=%b exp=0", imem_req); end
    step();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_req_discard got=%b exp=0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_req_stale_resp got=%b exp=0", imem_req); end
    lat = 1;
    step();
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL rw_dropped got=%b exp=0", valid_d); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rw_req_resume got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL rw_target_addr got=%h exp=00000100", imem_addr); end
    repeat (2) step();
    checks++; if (pop_pc.size() != 0) begin failures++; $display("FAIL rw_no_stale_pop got=%0d exp=0", pop_pc.size()); end
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h100 || instr_d !== 32'hDEAD_0100) begin
      failures++; $display("FAIL rw_target_entry got=%b/%h/%h exp=1/00000100/dead0100", valid_d, pc_d, instr_d);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    ready_d = 1'b0;
    repeat (3) step();
    checks++; if (valid_d !== 1'b1 || imem_rvalid !== 1'b1) begin
      failures++; $display("FAIL rr_setup got=%b/%b exp=1/1", valid_d, imem_rvalid);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    ready_d     = 1'b1;
    step();
    redirect = 1'b0;
    #1;
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL rr_flushed got=%b exp=0", valid_d); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++; $display("FAIL rr_next_req got=%b/%h exp=1/00000200", imem_req, imem_addr);
    end
    repeat (2) step();
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200 || instr_d !== 32'hDEAD_0200) begin
      failures++; $display("FAIL rr_target_entry got=%b/%h/%h exp=1/00000200/dead0200", valid_d, pc_d, instr_d);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ready_d = 1'b1;
    mem_en  = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || valid_d !== 1'b0) begin
      failures++; $display("FAIL rm_async_reset got=%b/%b exp=0/0", imem_req, valid_d);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    pending     = 1'b0;
    mem_en      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rm_first_req got=%b/%h exp=1/00000000", imem_req, imem_addr);
    end
    step();
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL rm_stale_ignored got=%b exp=0", valid_d); end
    step();
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== 32'hDEAD_0000) begin
      failures++; $display("FAIL rm_first_entry got=%b/%h/%h exp=1/00000000/dead0000", valid_d, pc_d, instr_d);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ready_d     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_req_in_redirect got=%b exp=0", imem_req); end
    step();
    redirect = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    repeat (8) step();
    checks++; if (pop_pc.size() < 2) begin failures++; $display("FAIL wrap_pop_count got=%0d exp>=2", pop_pc.size()); end
    if (pop_pc.size() >= 2) begin
      checks++; if (pop_pc[0] !== 32'hFFFF_FFFC || pop_pp4[0] !== 32'h0) begin
        failures++; $display("FAIL wrap_entry0 got=%h/%h exp=fffffffc/00000000", pop_pc[0], pop_pp4[0]);
      end
      checks++; if (pop_pc[1] !== 32'h0 || pop_pp4[1] !== 32'h4) begin
        failures++; $display("FAIL wrap_entry1 got=%h/%h exp=00000000/00000004", pop_pc[1], pop_pp4[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_reset_mid_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
